// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_divisor};

    // With a zero divisor every step "fits", which yields an all-ones quotient and remainder = dividend.
    always_comb begin
        o_qBit = 1'b0;
        o_rem  = w_trial[WIDTH-1:0];
        if (w_trial >= {1'b0, i_divisor}) begin
            o_qBit = 1'b1;
            o_rem  = w_diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_ry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_r;
    logic             r_done;
    logic             r_dz;
    logic             r_dzPending;

    logic [WIDTH-1:0] w_nextRa;
    logic             w_qBit;
    logic [WIDTH-1:0] w_nextRy;
    logic             w_lastStep;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_ra),
        .i_bit     (r_ry[WIDTH-1]),
        .i_divisor (r_rb),
        .o_rem     (w_nextRa),
        .o_qBit    (w_qBit)
    );

    assign w_nextRy   = {r_ry[WIDTH-2:0], w_qBit};
    assign w_lastStep = (r_state == BUSY) && (r_count == CW'(1));

    // The completion commit is evaluated before the load so that ld on the final edge both finishes and restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ra        <= '0;
            r_rb        <= '0;
            r_ry        <= '0;
            r_count     <= '0;
            r_y         <= '0;
            r_r         <= '0;
            r_done      <= 1'b0;
            r_dz        <= 1'b0;
            r_dzPending <= 1'b0;
        end else begin
            r_done <= w_lastStep;
            if (w_lastStep) begin
                r_y  <= w_nextRy;
                r_r  <= w_nextRa;
                r_dz <= r_dzPending;
            end
            if (ld) begin
                r_state     <= BUSY;
                r_ra        <= '0;
                r_rb        <= b;
                r_ry        <= a;
                r_count     <= CW'(WIDTH);
                r_dzPending <= (b == '0);
            end else if (r_state == BUSY) begin
                r_ra    <= w_nextRa;
                r_ry    <= w_nextRy;
                r_count <= r_count - CW'(1);
                if (w_lastStep) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign y    = r_y;
    assign r    = r_r;
    assign busy = (r_state == BUSY);
    assign done = r_done;
    assign dz   = r_dz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus random traffic against a plain-arithmetic reference.
module tb_seq_div;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         ld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         dz;

    int vectors;
    int miscompares;

    // Reference model state: the operation in flight and the last committed results.
    logic         mBusy;
    int           mLeft;
    logic [W-1:0] mA;
    logic [W-1:0] mB;
    logic [W-1:0] expY;
    logic [W-1:0] expR;
    logic         expDz;
    logic         expDone;

    seq_div #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .y    (y),
        .r    (r),
        .busy (busy),
        .done (done),
        .dz   (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        mBusy   = 1'b0;
        mLeft   = 0;
        mA      = '0;
        mB      = '0;
        expY    = '0;
        expR    = '0;
        expDz   = 1'b0;
        expDone = 1'b0;
    endtask

    // Advance the model by one rising edge given what the DUT sampled.
    task automatic modelEdge(input logic ldv, input logic [W-1:0] av, input logic [W-1:0] bv);
        expDone = 1'b0;
        if (mBusy) begin
            mLeft--;
            if (mLeft == 0) begin
                expY    = (mB == 0) ? {W{1'b1}} : W'(mA / mB);
                expR    = (mB == 0) ? mA : W'(mA % mB);
                expDz   = (mB == 0);
                expDone = 1'b1;
                mBusy   = 1'b0;
            end
        end
        if (ldv) begin
            mBusy = 1'b1;
            mLeft = W;
            mA    = av;
            mB    = bv;
        end
    endtask

    task automatic checkAll();
        checkOutput("y", y, expY);
        checkOutput("r", r, expR);
        checkOutput("dz", dz, expDz);
        checkOutput("done", done, expDone);
        checkOutput("busy", busy, mBusy);
    endtask

    // Drive inputs (called at a falling edge), take one rising edge, then check at the next falling edge.
    task automatic applyStimulus(input logic ldv, input logic [W-1:0] av, input logic [W-1:0] bv);
        ld = ldv;
        a  = av;
        b  = bv;
        @(posedge clk);
        modelEdge(ldv, av, bv);
        @(negedge clk);
        checkAll();
    endtask

    task automatic runOp(input logic [W-1:0] av, input logic [W-1:0] bv);
        applyStimulus(1'b1, av, bv);
        repeat (W) applyStimulus(1'b0, '0, '0);
    endtask

    task automatic midReset();
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("rst_y", y, 0);
        checkOutput("rst_r", r, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        ld  = 1'b0;
        a   = '0;
        b   = '0;
        resetModel();
        #12;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        runOp(4'b1011, 4'b0010);
        checkOutput("tp1_y", y, 4'b0101);
        checkOutput("tp1_r", r, 4'b0001);

        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b1001, 4'b1000);
        applyStimulus(1'b0, '0, '0);
        checkOutput("tp2_hold_y", y, 4'b0101);
        repeat (W - 1) applyStimulus(1'b0, '0, '0);
        checkOutput("tp2_y", y, 4'b0001);
        checkOutput("tp2_r", r, 4'b0001);

        runOp(4'b0011, 4'b0111);
        checkOutput("tp3_y", y, 4'b0000);
        checkOutput("tp3_r", r, 4'b0011);
        runOp(4'b1111, 4'b0001);
        checkOutput("tp3b_y", y, 4'b1111);
        checkOutput("tp3b_r", r, 4'b0000);

        runOp(4'b0110, 4'b0000);
        checkOutput("tp4_y", y, 4'b1111);
        checkOutput("tp4_r", r, 4'b0110);
        checkOutput("tp4_dz", dz, 1);
        runOp(4'b0111, 4'b0010);
        checkOutput("tp4b_dz", dz, 0);

        applyStimulus(1'b1, 4'b1100, 4'b0011);
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b1110, 4'b0100);
        repeat (W) applyStimulus(1'b0, '0, '0);
        checkOutput("tp5_y", y, 4'b0011);
        checkOutput("tp5_r", r, 4'b0010);

        // Back-to-back: ld lands exactly on the completion edge, then ld held for several cycles.
        applyStimulus(1'b1, 4'b1101, 4'b0011);
        repeat (W - 1) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b1000, 4'b0011);
        applyStimulus(1'b1, 4'b1001, 4'b0010);
        repeat (W) applyStimulus(1'b0, '0, '0);

        applyStimulus(1'b1, 4'b1010, 4'b0011);
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b0, '0, '0);
        midReset();
        repeat (W + 1) applyStimulus(1'b0, '0, '0);
        runOp(4'b1011, 4'b0010);
        checkOutput("tp6_y", y, 4'b0101);

        for (int i = 0; i < 1500; i++) begin
            logic         ldv;
            logic [W-1:0] av;
            logic [W-1:0] bv;
            ldv = ($urandom_range(0, 4) == 0);
            av  = W'($urandom);
            bv  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                midReset();
            end else begin
                applyStimulus(ldv, av, bv);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
